hamming_tx_scheduler: RTL and testbench

Shares one Hamming(7,4) encoder between two nibble requesters using round-robin arbitration. Each granted nibble is encoded, and the 7-bit codeword is shifted out serially, position 1 first. The block sits between local data sources and a single-bit link serializer. It is the sequencing and arbitration front end for the team's Hamming parity datapath.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming_enc74.sv | 13 +
 rtl/hamming_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_hamming_tx_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types, widths and codeword ordering for the Hamming(7,4) transmit path
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;
    localparam int GAP_W  = 4;

    // Places parity and data bits at Hamming positions 1..7, position 1 at bit 0.
    // par is {P3, P2, P1}.
    function automatic logic [CW_W-1:0] cw_order(input logic [DATA_W-1:0] data,
                                                 input logic [2:0]        par);
        cw_order = {data[3], data[2], data[1], par[2], data[0], par[1], par[0]};
    endfunction

endpackage

// File: rtl/hamming_enc74.sv
// rtl/hamming_enc74.sv - combinational Hamming(7,4) parity generator
module hamming_enc74 (
    input  logic [3:0] data,
    output logic       p1,
    output logic       p2,
    output logic       p3
);

    assign p1 = data[0] ^ data[1] ^ data[3];
    assign p2 = data[0] ^ data[2] ^ data[3];
    assign p3 = data[1] ^ data[2] ^ data[3];

endmodule

// File: rtl/hamming_tx_scheduler.sv
// rtl/hamming_tx_scheduler.sv - round-robin two-requester Hamming(7,4) encoder with serial frame output
module hamming_tx_scheduler
    import hamming_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req0_valid,
    input  logic [3:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_data,
    output logic       req1_ready,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_sof,
    output logic       ser_id,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    state_t            state;
    logic [2:0]        bit_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CW_W-1:0]   shreg;
    logic              last_grant;
    // Holds the accept window shut during reset and the first edge after it,
    // so both ready lines read 0 while rst_n is low.
    logic              run;

    logic              tail;
    logic              window;
    logic              winner;
    logic              accept;
    logic [DATA_W-1:0] win_data;
    logic              p1;
    logic              p2;
    logic              p3;
    logic [CW_W-1:0]   cw;

    // Tail cycle: last cycle of the frame (no gap) or of the gap, where the next grant may land.
    assign tail = ((state == SHIFT) && (bit_idx == 3'd6) && (GAP == 0)) ||
                  ((state == hamming_pkg::GAP) && (gap_cnt == GAP_W'(GAP - 1)));

    assign window = run && enable && ((state == IDLE) || tail);

    // A lone requester wins outright; on a tie the side not granted last time wins.
    assign winner = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept = window && (req0_valid || req1_valid);

    assign req0_ready = window && !winner && req0_valid;
    assign req1_ready = window &&  winner && req1_valid;

    assign win_data = winner ? req1_data : req0_data;

    hamming_enc74 u_enc (
        .data (win_data),
        .p1   (p1),
        .p2   (p2),
        .p3   (p3)
    );

    assign cw = cw_order(win_data, {p3, p2, p1});

    // Frame sequencer: captures the codeword on accept, shifts it out, then gaps or idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            last_grant <= 1'b1;
            run        <= 1'b0;
            ser_bit    <= 1'b0;
            ser_valid  <= 1'b0;
            ser_sof    <= 1'b0;
            ser_id     <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            run     <= 1'b1;
            ser_sof <= 1'b0;

            if ((state == SHIFT) && (bit_idx == 3'd6)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (accept) begin
                state      <= SHIFT;
                bit_idx    <= '0;
                shreg      <= cw >> 1;
                ser_bit    <= cw[0];
                ser_valid  <= 1'b1;
                ser_sof    <= 1'b1;
                ser_id     <= winner;
                last_grant <= winner;
                busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                    SHIFT: begin
                        if (bit_idx != 3'd6) begin
                            bit_idx <= bit_idx + 3'd1;
                            ser_bit <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else begin
                            ser_bit   <= 1'b0;
                            ser_valid <= 1'b0;
                            if (GAP > 0) begin
                                state   <= hamming_pkg::GAP;
                                gap_cnt <= '0;
                                busy    <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    hamming_pkg::GAP: begin
                        if (tail) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// tb/tb_hamming_tx_scheduler.sv - directed self-checking bench for hamming_tx_scheduler
module tb_hamming_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req1_valid;
    logic [3:0] req1_data;

    logic       a_ready0, a_ready1, a_bit, a_valid, a_sof, a_id, a_busy;
    logic [7:0] a_cnt;
    logic       b_ready0, b_ready1, b_bit, b_valid, b_sof, b_id, b_busy;
    logic [7:0] b_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hamming_tx_scheduler #(.GAP(1)) u_dut_gap1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (a_ready0),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (a_ready1),
        .ser_bit    (a_bit),
        .ser_valid  (a_valid),
        .ser_sof    (a_sof),
        .ser_id     (a_id),
        .busy       (a_busy),
        .frame_cnt  (a_cnt)
    );

    hamming_tx_scheduler #(.GAP(0)) u_dut_gap0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (b_ready0),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (b_ready1),
        .ser_bit    (b_bit),
        .ser_valid  (b_valid),
        .ser_sof    (b_sof),
        .ser_id     (b_id),
        .busy       (b_busy),
        .frame_cnt  (b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
    endtask

    task automatic wait_sof(input bit use_b, output bit found, output int at);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (use_b ? b_sof : a_sof) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
    endtask

    task automatic read_frame(input bit use_b, output logic [6:0] bits, output logic id,
                              output bit allv, output bit extra_sof);
        bits[0]   = use_b ? b_bit : a_bit;
        id        = use_b ? b_id : a_id;
        allv      = use_b ? b_valid : a_valid;
        extra_sof = 1'b0;
        for (int k = 1; k < 7; k++) begin
            step();
            bits[k]   = use_b ? b_bit : a_bit;
            allv      = allv & (use_b ? b_valid : a_valid);
            extra_sof = extra_sof | (use_b ? b_sof : a_sof);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 4'h5;
        req1_data  = 4'hA;
        #3;
        checks++;
        if ({a_ready0, a_ready1, a_bit, a_valid, a_sof, a_id, a_busy, a_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %0h required all zero",
                     {a_ready0, a_ready1, a_bit, a_valid, a_sof, a_id, a_busy}, a_cnt);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({a_busy, a_ready0, a_ready1, a_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b required 0000",
                     {a_busy, a_ready0, a_ready1, a_valid});
        end
    endtask

    task automatic test_single();
        logic [6:0] exp_bits = 7'b1010101;
        req0_data  = 4'b1011;
        req0_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready0, a_ready1} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b required 10", {a_ready0, a_ready1});
        end
        step();
        req0_valid = 1'b0;
        req0_data  = 4'h0;
        checks++;
        if ({a_sof, a_valid, a_id, a_bit, a_busy} !== 5'b11011) begin
            errors++;
            $display("FAIL single_first: got %b required 11011", {a_sof, a_valid, a_id, a_bit, a_busy});
        end
        for (int k = 1; k < 7; k++) begin
            step();
            checks++;
            if ({a_sof, a_valid, a_bit} !== {1'b0, 1'b1, exp_bits[k]}) begin
                errors++;
                $display("FAIL single_bit%0d: got sof/valid/bit %b required %b", k,
                         {a_sof, a_valid, a_bit}, {1'b0, 1'b1, exp_bits[k]});
            end
        end
        step();
        checks++;
        if ({a_valid, a_bit, a_busy, a_cnt} !== {3'b001, 8'd1}) begin
            errors++;
            $display("FAIL single_gap: got valid/bit/busy %b cnt %0d required 001 cnt 1",
                     {a_valid, a_bit, a_busy}, a_cnt);
        end
        step();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %b required 0", a_busy);
        end
    endtask

    task automatic test_tie();
        bit         f;
        int         s1, s2, s3;
        logic [6:0] bits;
        logic       id;
        bit         allv, xs;
        apply_reset();
        req0_data  = 4'h0;
        req1_data  = 4'hF;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready0, a_ready1} !== 2'b10) begin
            errors++;
            $display("FAIL tie_ready: got %b required 10", {a_ready0, a_ready1});
        end
        wait_sof(1'b0, f, s1);
        read_frame(1'b0, bits, id, allv, xs);
        checks++;
        if ({f, id, bits, allv, xs} !== {1'b1, 1'b0, 7'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tie_frame_a: got found/id/bits/valid/sof %b %b %b %b %b required 1 0 0000000 1 0",
                     f, id, bits, allv, xs);
        end
        wait_sof(1'b0, f, s2);
        read_frame(1'b0, bits, id, allv, xs);
        checks++;
        if ({f, id, bits, allv, xs} !== {1'b1, 1'b1, 7'h7F, 1'b1, 1'b0} || (s2 - s1) != 8) begin
            errors++;
            $display("FAIL tie_frame_b: got found/id/bits %b %b %b pitch %0d required 1 1 1111111 pitch 8",
                     f, id, bits, s2 - s1);
        end
        wait_sof(1'b0, f, s3);
        checks++;
        if (f !== 1'b1 || a_id !== 1'b0 || (s3 - s2) != 8) begin
            errors++;
            $display("FAIL tie_third: got found %b id %b pitch %0d required 1 0 8", f, a_id, s3 - s2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit         f;
        int         s_prev, s_now;
        logic [6:0] bits;
        logic       id;
        bit         allv, xs;
        apply_reset();
        req0_data  = 4'h1;
        req0_valid = 1'b1;
        wait_sof(1'b1, f, s_prev);
        checks++;
        if (f !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: got found %b required 1", f);
        end
        for (int n = 0; n < 3; n++) begin
            read_frame(1'b1, bits, id, allv, xs);
            step();
            s_now = cyc;
            checks++;
            if ({bits, id, allv, xs, b_sof, b_valid} !== {7'b0000111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1} ||
                (s_now - s_prev) != 7) begin
                errors++;
                $display("FAIL b2b_frame%0d: got bits %b id %b valid %b next sof/valid %b pitch %0d required 0000111 0 1 11 pitch 7",
                         n, bits, id, allv, {b_sof, b_valid}, s_now - s_prev);
            end
            s_prev = s_now;
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_enable_mid();
        bit         f;
        int         s;
        logic [6:0] exp_bits = 7'b1010101;
        bit         leak;
        apply_reset();
        req0_data  = 4'b1011;
        req0_valid = 1'b1;
        wait_sof(1'b0, f, s);
        step();
        step();
        step();
        checks++;
        if ({f, a_valid, a_bit} !== {1'b1, 1'b1, exp_bits[3]}) begin
            errors++;
            $display("FAIL en_bit3: got found/valid/bit %b required 11%b", {f, a_valid, a_bit}, exp_bits[3]);
        end
        enable = 1'b0;
        for (int k = 4; k < 7; k++) begin
            step();
            checks++;
            if ({a_valid, a_bit} !== {1'b1, exp_bits[k]}) begin
                errors++;
                $display("FAIL en_finish_bit%0d: got valid/bit %b required 1%b", k, {a_valid, a_bit}, exp_bits[k]);
            end
        end
        leak = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            leak = leak | a_ready0 | a_ready1 | a_valid;
        end
        checks++;
        if ({leak, a_busy, a_cnt} !== {2'b00, 8'd1}) begin
            errors++;
            $display("FAIL en_blocked: got leak/busy %b cnt %0d required 00 cnt 1", {leak, a_busy}, a_cnt);
        end
        enable     = 1'b1;
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit f;
        int s;
        apply_reset();
        req0_data  = 4'b1011;
        req0_valid = 1'b1;
        wait_sof(1'b0, f, s);
        req0_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({f, a_valid} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_inflight: got found/valid %b required 11", {f, a_valid});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_busy, a_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL rstmid_abort: got valid/busy %b cnt %0d required 00 cnt 0", {a_valid, a_busy}, a_cnt);
        end
        req0_data  = 4'h0;
        req1_data  = 4'hF;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        rst_n = 1'b1;
        wait_sof(1'b0, f, s);
        checks++;
        if ({f, a_id} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_tie: got found/id %b required 10", {f, a_id});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_wrap();
        bit f;
        int s;
        apply_reset();
        req0_data  = 4'h1;
        req0_valid = 1'b1;
        wait_sof(1'b1, f, s);
        repeat (7 * 255 - 1) step();
        checks++;
        if ({f, b_cnt} !== {1'b1, 8'd254}) begin
            errors++;
            $display("FAIL wrap_254: got found %b cnt %0d required 1 cnt 254", f, b_cnt);
        end
        step();
        checks++;
        if (b_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d required 255", b_cnt);
        end
        repeat (7) step();
        checks++;
        if (b_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: got %0d required 0", b_cnt);
        end
        req0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 4'h0;
        req1_data  = 4'h0;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_enable_mid();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
